async_fifo_wr_arbiter: RTL and testbench

Round-robin arbiter sharing the `async_fifo` write port among `NREQ` requesters in the write clock domain. Each requester presents data over a valid/ready handshake. The arbiter grants one owner at a time for a bounded burst and drives `winc`/`wdata` into the FIFO. It never writes while `wfull` is high, so no beat is lost or duplicated.

---
 rtl/async_fifo_pkg.sv | 39 +++
 rtl/async_fifo_wr_arbiter_if.sv | 30 +++
 rtl/async_fifo_wr_arbiter_rr_picker.sv | 25 ++
 rtl/async_fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_async_fifo_wr_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async_fifo write-port arbiter.
// Holds the arbiter FSM states, clog2 and the round-robin search.
package async_fifo_pkg;

    localparam int MAXREQ = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Unused upper request bits are zero, so a 16-wide circular
    // search from ptr gives the same winner as a modulo-NREQ one.
    function automatic logic [3:0] rr_pick(
        input logic [MAXREQ-1:0] valid,
        input logic [3:0]        ptr
    );
        logic [3:0] j;
        rr_pick = ptr;
        for (int k = MAXREQ - 1; k >= 0; k--) begin
            j = ptr + 4'(k);
            if (valid[j]) begin
                rr_pick = j;
            end
        end
    endfunction

endpackage

// File: rtl/async_fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for async_fifo_wr_arbiter.
// master = arbiter side, slave = requesters plus FIFO side.
interface async_fifo_wr_arbiter_if
    import async_fifo_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DSIZE = 32
);
    localparam int IDW = clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  wfull;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );

endinterface

// File: rtl/async_fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin search over NREQ request bits.
// Returns the first set index at or above ptr, wrapping.
module rr_picker
    import async_fifo_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [MAXREQ-1:0] v16;
    logic [3:0]        p4;
    logic [3:0]        pick;

    assign v16   = MAXREQ'(valid);
    assign p4    = 4'(ptr);
    assign pick  = rr_pick(v16, p4);
    assign idx   = IDW'(pick);
    assign found = |valid;

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin arbiter for the async_fifo write port, bounded bursts.
// ASYNC_FIFO_ARB_TAG_EN: overwrite top IDW data bits with the owner.
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 32,
    parameter int MAXBURST = 8
) (
    input logic                   wclk,
    input logic                   wrst,
    async_fifo_wr_arbiter_if.master bus
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = clog2(MAXBURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAXBURST - 1);

    arb_state_t     state, state_nx;
    logic [IDW-1:0] own, own_nx;
    logic [IDW-1:0] ptr, ptr_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [IDW-1:0] pick_idx;
    logic           pick_found;
    logic [IDW-1:0] own_inc;
    logic           own_valid;
    logic           acc;
    logic [DSIZE-1:0] own_data;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign own_valid = bus.req_valid[own];
    assign own_data  = bus.req_data[int'(own)*DSIZE +: DSIZE];
    assign own_inc   = (int'(own) == NREQ - 1) ? '0 : own + 1'b1;

    // Next-state: grant on any request, release on drop or burst end.
    always_comb begin
        state_nx = state;
        own_nx   = own;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        acc      = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_nx = ARB_GRANT;
                    own_nx   = pick_idx;
                    cnt_nx   = '0;
                end
            end
            ARB_GRANT: begin
                acc = own_valid & ~bus.wfull;
                if (!own_valid) begin
                    state_nx = ARB_IDLE;
                    ptr_nx   = own_inc;
                end else if (acc) begin
                    if (cnt == LAST) begin
                        state_nx = ARB_IDLE;
                        ptr_nx   = own_inc;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // Owner, priority pointer and beat counter registers.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state <= ARB_IDLE;
            own   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            own   <= own_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

    assign bus.winc      = acc;
    assign bus.req_ready = acc ? (NREQ'(1) << own) : '0;
    assign bus.busy      = (state == ARB_GRANT);
    assign bus.grant_id  = own;

`ifdef ASYNC_FIFO_ARB_TAG_EN
    assign bus.wdata = {own, own_data[DSIZE-IDW-1:0]};
`else
    assign bus.wdata = own_data;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Bench for async_fifo_wr_arbiter with a 16-deep FIFO model.
// Per-cycle model compare plus directed literal expectations.
module tb_async_fifo_wr_arbiter;
    import async_fifo_pkg::*;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 32;
    localparam int MAXBURST = 8;
    localparam int DEPTH    = 16;

`ifdef ASYNC_FIFO_ARB_TAG_EN
    localparam logic [31:0] EXP_A  = 32'h8000_000A;
    localparam logic [31:0] EXP_B  = 32'h8000_000B;
    localparam logic [31:0] EXP_C  = 32'h8000_000C;
    localparam logic [31:0] EXP_T3 = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_T1 = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] EXP_A  = 32'h0000_000A;
    localparam logic [31:0] EXP_B  = 32'h0000_000B;
    localparam logic [31:0] EXP_C  = 32'h0000_000C;
    localparam logic [31:0] EXP_T3 = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_T1 = 32'hFFFF_FFFF;
`endif

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    logic wfull_r = 1'b0;
    logic rd_en = 1'b0;
    logic seq_mode = 1'b0;

    always #5 wclk = ~wclk;

    async_fifo_wr_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus();

    assign bus.wfull = wfull_r;

    async_fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (MAXBURST)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] sq [NREQ][$];
    logic [31:0] fq[$];
    logic [31:0] exp_fifo[$];
    logic [31:0] rd_log[$];
    int          grant_log[$];
    int          burst_log[$];
    int          rd_seq [NREQ];
    int          wr_seq [NREQ];
    logic [NREQ-1:0] rdy_s = '0;

    int m_own = -1;
    int m_prio = 0;
    int m_gid = 0;
    int m_beats = 0;
    int acc_total = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wdata(input int src,
                                              input logic [31:0] d);
        logic [31:0] r;
        r = d;
`ifdef ASYNC_FIFO_ARB_TAG_EN
        r[31:30] = 2'(src);
`else
        if (src < 0) r = '0;
`endif
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i] = (sq[i].size() > 0);
            bus.req_data[i*DSIZE +: DSIZE] =
                (sq[i].size() > 0) ? sq[i][0] : '0;
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (rdy_s[i] && sq[i].size() > 0) begin
                void'(sq[i].pop_front());
            end
        end
        drive();
    endtask

    function automatic int pending();
        int p;
        p = fq.size() + int'(bus.busy);
        for (int i = 0; i < NREQ; i++) p += sq[i].size();
        return p;
    endfunction

    task automatic wait_drain(input string name, input int limit);
        for (int c = 0; c < limit; c++) begin
            if (pending() == 0) break;
            step();
        end
        check(name, pending(), 0);
    endtask

    task automatic push_seq(input int i, input int n);
        for (int s = 0; s < n; s++) begin
            sq[i].push_back({4'h0, 4'(i), 8'h00, 16'(wr_seq[i])});
            wr_seq[i]++;
        end
    endtask

    // Arbiter model: owner -1 means idle; compares every cycle.
    logic [NREQ-1:0] mv;
    logic            mtake;
    logic [31:0]     mdat;
    int              mj;
    always @(negedge wclk) begin
        mv = bus.req_valid;
        rdy_s = bus.req_ready;
        if (wrst) begin
            check("rst_winc", bus.winc, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_ready", bus.req_ready, 0);
            check("rst_grant_id", bus.grant_id, 0);
            m_own = -1;
            m_prio = 0;
            m_gid = 0;
            m_beats = 0;
        end else begin
            mtake = (m_own >= 0) && mv[m_own] && !wfull_r;
            check("winc", bus.winc, mtake);
            check("req_ready", bus.req_ready,
                  mtake ? (1 << m_own) : 0);
            check("busy", bus.busy, m_own >= 0);
            check("grant_id", bus.grant_id, m_gid);
            if (mtake) begin
                mdat = exp_wdata(m_own, sq[m_own][0]);
                check("wdata", bus.wdata, mdat);
                exp_fifo.push_back(mdat);
                acc_total++;
            end
            if (m_own < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    mj = (m_prio + k) % NREQ;
                    if (m_own < 0 && mv[mj]) begin
                        m_own = mj;
                        m_gid = mj;
                        m_beats = 0;
                        grant_log.push_back(mj);
                    end
                end
            end else if (!mv[m_own]) begin
                burst_log.push_back(m_beats);
                m_prio = (m_own + 1) % NREQ;
                m_own = -1;
            end else if (mtake) begin
                m_beats++;
                if (m_beats == MAXBURST) begin
                    burst_log.push_back(m_beats);
                    m_prio = (m_own + 1) % NREQ;
                    m_own = -1;
                end
            end
        end
    end

    // FIFO model with registered full; checks read order.
    logic [31:0] rd_d;
    int          rd_src;
    always @(posedge wclk) begin
        if (bus.winc) begin
            check("fifo_room", fq.size() < DEPTH, 1);
            fq.push_back(bus.wdata);
        end
        if (rd_en && fq.size() > 0) begin
            rd_d = fq.pop_front();
            rd_log.push_back(rd_d);
            check("fifo_have_exp", exp_fifo.size() > 0, 1);
            if (exp_fifo.size() > 0) begin
                check("fifo_order", rd_d, exp_fifo.pop_front());
            end
            if (seq_mode) begin
                rd_src = int'(rd_d[25:24]);
                check("seq", rd_d[15:0], 16'(rd_seq[rd_src]));
                rd_seq[rd_src]++;
            end
        end
        wfull_r <= (fq.size() >= DEPTH);
    end

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            rd_seq[i] = 0;
            wr_seq[i] = 0;
        end
        wrst = 1'b1;
        repeat (5) @(posedge wclk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_winc", bus.winc, 0);
        wrst = 1'b0;

        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            check("idle_winc", bus.winc, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_ready", bus.req_ready, 0);
        end

        sq[2].push_back(32'hA);
        sq[2].push_back(32'hB);
        sq[2].push_back(32'hC);
        drive();
        for (int c = 0; c < 3; c++) begin
            logic [31:0] e;
            e = (c == 0) ? EXP_A : (c == 1) ? EXP_B : EXP_C;
            step();
            #1;
            check("single_winc", bus.winc, 1);
            check("single_wdata", bus.wdata, e);
            check("single_gid", bus.grant_id, 2);
        end
        step();
        #1;
        check("single_done", bus.winc, 0);
        rd_en = 1'b1;
        wait_drain("single_drain", 50);
        check("single_rd_n", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("single_rd0", rd_log[0], EXP_A);
            check("single_rd1", rd_log[1], EXP_B);
            check("single_rd2", rd_log[2], EXP_C);
        end

        wrst = 1'b1;
        step();
        step();
        wrst = 1'b0;
        grant_log.delete();
        burst_log.delete();
        seq_mode = 1'b1;
        for (int i = 0; i < NREQ; i++) push_seq(i, 16);
        drive();
        wait_drain("cont_drain", 300);
        check("cont_grants", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) begin
            check("cont_order", grant_log[k], k % NREQ);
        end
        for (int k = 0; k < burst_log.size(); k++) begin
            check("cont_burst", burst_log[k], MAXBURST);
        end
        for (int i = 0; i < NREQ; i++) begin
            check("cont_count", rd_seq[i], 16);
        end

        rd_en = 1'b0;
        acc_total = 0;
        push_seq(0, 20);
        drive();
        repeat (60) step();
        #1;
        check("bp_accepted", acc_total, 16);
        check("bp_fifo_level", fq.size(), 16);
        check("bp_wfull", wfull_r, 1);
        check("bp_busy", bus.busy, 1);
        check("bp_winc", bus.winc, 0);
        check("bp_left", sq[0].size(), 4);
        rd_en = 1'b1;
        wait_drain("bp_drain", 200);
        check("bp_total", acc_total, 20);
        check("bp_seq", rd_seq[0], 36);

        acc_total = 0;
        push_seq(0, 8);
        push_seq(1, 8);
        drive();
        for (int c = 0; c < 50; c++) begin
            if (acc_total >= 2) break;
            step();
        end
        #1;
        check("mid_winc", bus.winc, 1);
        check("mid_gid", bus.grant_id, 1);
        wrst = 1'b1;
        #1;
        check("mid_rst_winc", bus.winc, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_ready", bus.req_ready, 0);
        step();
        step();
        wrst = 1'b0;
        step();
        #1;
        check("mid_after_busy", bus.busy, 1);
        check("mid_after_gid", bus.grant_id, 0);
        wait_drain("mid_drain", 200);
        check("mid_seq0", rd_seq[0], wr_seq[0]);
        check("mid_seq1", rd_seq[1], wr_seq[1]);

        seq_mode = 1'b0;
        rd_log.delete();
        sq[3].push_back(32'hFFFF_FFFF);
        drive();
        wait_drain("tag3_drain", 50);
        sq[1].push_back(32'hFFFF_FFFF);
        drive();
        wait_drain("tag1_drain", 50);
        check("tag_rd_n", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("tag_rd3", rd_log[0], EXP_T3);
            check("tag_rd1", rd_log[1], EXP_T1);
        end
        check("exp_left", exp_fifo.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
